turf_plot_sink: RTL and testbench
=================================

Name: turf_plot_sink

Overview:
- Receiving end of the plot command stream (x, y, colour, plot) that the player draw sequencer generates.
- Buffers commands in a small FIFO and writes each one into the 32768x3 game RAM at address {x, y}.
- Does a read-modify-write per command and keeps a live pixel count for each of the four players, so territory totals are tracked without a full-frame read scan.
- Also provides a sweep that clears the whole board.

Parameters:
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width; RAM address width = X_W+Y_W = 15.
- COLOUR_W, 3, colour/RAM data width.
- FIFO_DEPTH, 4, command FIFO entries (power of two).
- COUNT_W, 15, width of each player count.

Ports:
- CLOCK_50  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- x  in  8  plot x coordinate.
- y  in  7  plot y coordinate.
- colour  in  3  plot colour.
- plot  in  1  command valid; accepted on a rising edge where plot && ready.
- ready  out  1  FIFO not full and no clear in progress.
- clear  in  1  single-cycle request to clear the board and the counts.
- busy  out  1  command in flight, FIFO non-empty, or clear sweep active.
- dropped  out  1  sticky flag: a plot was asserted while ready was low.
- ram_address  out  15  {x, y} address to the game RAM.
- ram_data  out  3  write data.
- ram_wren  out  1  write enable.
- ram_q  in  3  RAM read data; valid one cycle after ram_address is presented (address registered inside the RAM, output unregistered).
- p1_count, p2_count, p3_count, p4_count  out  15 each  pixels currently owned by each player.

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to IDLE and the FIFO empties.
  - All counts are 0; dropped = 0; ram_wren = 0; ram_address = 0; ram_data = 0.
  - busy = 0; ready = 1 in the cycle after reset deasserts.
  - RAM contents are not touched.
  - Reset mid-command abandons the command with no write.
- Colour-to-player map:
  - 001 = p1, 010 = p2, 100 = p3, 110 = p4.
  - 000 = background.
  - 011, 101, 111 are written to RAM but counted for nobody.
- FSM states:
  - IDLE: if a clear is pending, go to CLEAR. Otherwise, if the FIFO is non-empty, go to READ. Otherwise stay in IDLE.
  - READ: drive ram_address = head {x, y}; ram_wren = 0; go to UPDATE.
  - UPDATE:
    - ram_q holds the old colour.
    - If old != new: ram_wren = 1, ram_data = new; decrement the old owner's count (if mapped); increment the new owner's count (if mapped).
    - If old == new: no write and no count change.
    - Pop the FIFO. Next state is READ if the FIFO still holds entries and no clear is pending, otherwise IDLE.
  - CLEAR:
    - Counts are zeroed on entry and the FIFO is flushed.
    - Writes 000 to addresses 0..32767, one per cycle: ram_wren = 1, ram_address increments.
    - Returns to IDLE after address 32767 (32768 cycles).
- Throughput: one command per 2 cycles (READ, UPDATE). Latency from push into an empty FIFO to the write is 3 cycles: push edge, READ, UPDATE.
- Simultaneous events:
  - A push and a pop on the same edge are both honoured.
  - A clear that arrives during READ or UPDATE is latched and taken after that UPDATE completes. Remaining FIFO entries are discarded.
  - A clear that arrives during CLEAR is ignored.
  - A plot arriving on the same edge as clear is dropped.
  - ready = 0 from the latching of the clear until CLEAR exits.
- Overflow:
  - A plot asserted while ready = 0 is discarded and dropped is set.
  - dropped is cleared only by reset or by entry to CLEAR.
- Count arithmetic:
  - Increment saturates at 32767.
  - Decrement floors at 0.
  - Both rules are defensive only; consistent operation never reaches either limit except when all 32768 cells are owned by one player.
- Address formation: address = {x, y}. Out-of-range y (120..127) is still written; callers are responsible for range.

Decomposition:
- Shared package turf_pkg:
  - Address/colour/count widths.
  - Colour constants P1_COL = 3'b001, P2_COL = 3'b010, P3_COL = 3'b100, P4_COL = 3'b110, BG_COL = 3'b000.
  - FSM state encoding.
- One sub-module: plot_fifo, a synchronous FIFO of width 18 ({x, y, colour}).
  - Interface: push, pop, flush, full, empty, head.
  - Simultaneous push/pop is legal when full.

Test Plan:
- Reset, then plot (x=5, y=3, colour=001) into a zeroed RAM:
  - ram_wren = 1 at address 0x0283 with data 001 three cycles after the push.
  - p1_count = 1.
- Plot the same pixel again with 001: no ram_wren and p1_count stays 1. Then plot it with 010: write occurs, p1_count = 0, p2_count = 1.
- Push 6 plots on consecutive cycles with FIFO_DEPTH = 4:
  - ready drops and at least one plot is lost.
  - dropped = 1.
  - Every accepted command is written in order.
  - The counts equal the number of distinct accepted pixels per colour.
- Assert clear in the same cycle as an UPDATE:
  - That write completes.
  - CLEAR then writes 000 to every address 0..32767.
  - All counts read 0, dropped = 0, ready = 1 after 32768 cycles.
- Plot colour 011 over a p3 pixel:
  - Write occurs and p3_count decrements.
  - No count increments.
- Assert reset during UPDATE:
  - Next cycle ram_wren = 0 and all counts are 0.
  - The FIFO is empty and busy = 0.

Source files
------------

// File: rtl/turf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | turf_pkg                                                                   |
// | Shared widths, player colours, FSM encoding and colour-to-player helper.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package turf_pkg;

    localparam int TURF_X_W         = 8;
    localparam int TURF_Y_W         = 7;
    localparam int TURF_ADDR_W      = TURF_X_W + TURF_Y_W;
    localparam int TURF_COLOUR_W    = 3;
    localparam int TURF_COUNT_W     = 15;
    localparam int TURF_NUM_PLAYERS = 4;

    localparam logic [TURF_COLOUR_W-1:0] BG_COL = 3'b000;
    localparam logic [TURF_COLOUR_W-1:0] P1_COL = 3'b001;
    localparam logic [TURF_COLOUR_W-1:0] P2_COL = 3'b010;
    localparam logic [TURF_COLOUR_W-1:0] P3_COL = 3'b100;
    localparam logic [TURF_COLOUR_W-1:0] P4_COL = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_UPDATE = 2'd2,
        ST_CLEAR  = 2'd3
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } owner_t;

    // Background and the unassigned colours belong to nobody.
    function automatic owner_t colour_owner(input logic [TURF_COLOUR_W-1:0] colour);
        owner_t o;
        o.valid = 1'b1;
        o.idx   = 2'd0;
        case (colour)
            P1_COL:  o.idx = 2'd0;
            P2_COL:  o.idx = 2'd1;
            P3_COL:  o.idx = 2'd2;
            P4_COL:  o.idx = 2'd3;
            default: o.valid = 1'b0;
        endcase
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/plot_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | plot_fifo                                                                  |
// | Synchronous command FIFO; push and pop together are legal even when full.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module plot_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic             last,
    output logic [WIDTH-1:0] head
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == (c_AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign last      = (r_count == (c_AW+1)'(1));
    assign head      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push && !rst && !flush) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/turf_plot_sink.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | turf_plot_sink                                                             |
// | Applies plot commands to the game RAM by read-modify-write, tracking live  |
// | per-player pixel counts; also sweeps the whole board to background.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module turf_plot_sink
    import turf_pkg::*;
#(
    parameter int X_W        = TURF_X_W,
    parameter int Y_W        = TURF_Y_W,
    parameter int COLOUR_W   = TURF_COLOUR_W,
    parameter int FIFO_DEPTH = 4,
    parameter int COUNT_W    = TURF_COUNT_W
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic [X_W-1:0]         x,
    input  logic [Y_W-1:0]         y,
    input  logic [COLOUR_W-1:0]    colour,
    input  logic                   plot,
    output logic                   ready,
    input  logic                   clear,
    output logic                   busy,
    output logic                   dropped,
    output logic [X_W+Y_W-1:0]     ram_address,
    output logic [COLOUR_W-1:0]    ram_data,
    output logic                   ram_wren,
    input  logic [COLOUR_W-1:0]    ram_q,
    output logic [COUNT_W-1:0]     p1_count,
    output logic [COUNT_W-1:0]     p2_count,
    output logic [COUNT_W-1:0]     p3_count,
    output logic [COUNT_W-1:0]     p4_count
);

    localparam int                  c_ADDR_W    = X_W + Y_W;
    localparam int                  c_CMD_W     = X_W + Y_W + COLOUR_W;
    localparam logic [COUNT_W-1:0]  c_COUNT_ONE = COUNT_W'(1);
    localparam logic [COUNT_W-1:0]  c_COUNT_MAX = '1;
    localparam logic [c_ADDR_W-1:0] c_ADDR_ONE  = c_ADDR_W'(1);
    localparam logic [c_ADDR_W-1:0] c_ADDR_LAST = '1;

    state_t                r_state;
    logic [c_ADDR_W-1:0]   r_ram_address;
    logic [COLOUR_W-1:0]   r_ram_data;
    logic                  r_clear_pend;
    logic                  r_dropped;
    logic [COUNT_W-1:0]    r_count [TURF_NUM_PLAYERS];

    logic                  w_fifo_push;
    logic                  w_fifo_pop;
    logic                  w_fifo_flush;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_fifo_last;
    logic [c_CMD_W-1:0]    w_fifo_head;
    logic [c_ADDR_W-1:0]   w_head_addr;
    logic [COLOUR_W-1:0]   w_head_colour;
    logic                  w_clear_req;
    logic                  w_more;
    logic                  w_changed;
    owner_t                w_old_owner;
    owner_t                w_new_owner;

    assign w_head_addr   = w_fifo_head[c_CMD_W-1:COLOUR_W];
    assign w_head_colour = w_fifo_head[COLOUR_W-1:0];

    assign ready        = !w_fifo_full && !r_clear_pend && (r_state != ST_CLEAR);
    assign busy         = (r_state != ST_IDLE) || !w_fifo_empty || r_clear_pend;
    assign dropped      = r_dropped;

    // A plot that coincides with a clear request is discarded.
    assign w_fifo_push  = plot && ready && !clear;
    assign w_fifo_pop   = (r_state == ST_UPDATE);
    assign w_clear_req  = r_clear_pend || clear;
    assign w_fifo_flush = (r_state == ST_IDLE) && w_clear_req;
    assign w_more       = !w_fifo_last || w_fifo_push;

    assign w_changed    = (ram_q != r_ram_data);
    assign w_old_owner  = colour_owner(ram_q);
    assign w_new_owner  = colour_owner(r_ram_data);

    // READ presents the head address directly so the RAM latches it at the end of READ.
    assign ram_address  = (r_state == ST_READ) ? w_head_addr : r_ram_address;
    assign ram_data     = r_ram_data;
    // Gating with reset keeps an interrupted UPDATE from committing its write.
    assign ram_wren     = !reset && (((r_state == ST_UPDATE) && w_changed) || (r_state == ST_CLEAR));

    assign p1_count = r_count[0];
    assign p2_count = r_count[1];
    assign p3_count = r_count[2];
    assign p4_count = r_count[3];

    plot_fifo #(
        .WIDTH (c_CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_plot_fifo (
        .clk   (CLOCK_50),
        .rst   (reset),
        .push  (w_fifo_push),
        .pop   (w_fifo_pop),
        .flush (w_fifo_flush),
        .din   ({x, y, colour}),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .last  (w_fifo_last),
        .head  (w_fifo_head)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_ram_address <= '0;
            r_ram_data    <= '0;
            r_clear_pend  <= 1'b0;
            r_dropped     <= 1'b0;
            for (int p = 0; p < TURF_NUM_PLAYERS; p++) begin
                r_count[p] <= '0;
            end
        end else begin
            if (plot && !ready) begin
                r_dropped <= 1'b1;
            end
            if (clear && (r_state != ST_CLEAR)) begin
                r_clear_pend <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_clear_req) begin
                        r_state       <= ST_CLEAR;
                        r_ram_address <= '0;
                        r_ram_data    <= BG_COL;
                        r_clear_pend  <= 1'b0;
                        r_dropped     <= 1'b0;
                        for (int p = 0; p < TURF_NUM_PLAYERS; p++) begin
                            r_count[p] <= '0;
                        end
                    end else if (!w_fifo_empty) begin
                        r_state <= ST_READ;
                    end
                end

                ST_READ: begin
                    r_ram_address <= w_head_addr;
                    r_ram_data    <= w_head_colour;
                    r_state       <= ST_UPDATE;
                end

                ST_UPDATE: begin
                    // Old and new colours differ here, so at most one owner loses and another gains.
                    if (w_changed) begin
                        for (int p = 0; p < TURF_NUM_PLAYERS; p++) begin
                            if (w_old_owner.valid && (w_old_owner.idx == 2'(p)) && (r_count[p] != '0)) begin
                                r_count[p] <= r_count[p] - c_COUNT_ONE;
                            end
                            if (w_new_owner.valid && (w_new_owner.idx == 2'(p)) && (r_count[p] != c_COUNT_MAX)) begin
                                r_count[p] <= r_count[p] + c_COUNT_ONE;
                            end
                        end
                    end
                    r_state <= (w_more && !w_clear_req) ? ST_READ : ST_IDLE;
                end

                ST_CLEAR: begin
                    r_ram_address <= r_ram_address + c_ADDR_ONE;
                    if (r_ram_address == c_ADDR_LAST) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_turf_plot_sink.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_turf_plot_sink                                                          |
// | Directed vectors and corner-case sequences against a behavioural game RAM. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_turf_plot_sink;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        ready;
    logic        clear;
    logic        busy;
    logic        dropped;
    logic [14:0] ram_address;
    logic [2:0]  ram_data;
    logic        ram_wren;
    logic [2:0]  ram_q;
    logic [14:0] p1_count;
    logic [14:0] p2_count;
    logic [14:0] p3_count;
    logic [14:0] p4_count;

    always #10 CLOCK_50 = ~CLOCK_50;

    turf_plot_sink dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .plot        (plot),
        .ready       (ready),
        .clear       (clear),
        .busy        (busy),
        .dropped     (dropped),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q),
        .p1_count    (p1_count),
        .p2_count    (p2_count),
        .p3_count    (p3_count),
        .p4_count    (p4_count)
    );

    // Game RAM: registered address, unregistered output, zero-initialised.
    logic [2:0]  mem [32768] = '{default: 3'b000};
    logic [14:0] q_addr = '0;
    always @(posedge CLOCK_50) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        q_addr <= ram_address;
    end
    assign ram_q = mem[q_addr];

    logic        log_en = 1'b0;
    logic [17:0] wlog [$];
    logic        clr_mon = 1'b0;
    int          clr_writes = 0;
    always @(posedge CLOCK_50) begin
        if (log_en && ram_wren) wlog.push_back({ram_address, ram_data});
        if (clr_mon && ram_wren && ram_data == 3'b000) clr_writes++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  vx;
        logic [6:0]  vy;
        logic [2:0]  vc;
        logic        wr;
        logic [14:0] e1;
        logic [14:0] e2;
        logic [14:0] e3;
        logic [14:0] e4;
    } vec_t;

    vec_t        vecs [10];
    logic [7:0]  bx [6];
    logic [2:0]  bc [6];
    logic [17:0] exp_log [5];

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    initial begin : watchdog
        #5_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cyc;
        int bad;
        logic [17:0] act;

        vecs[0] = '{8'd5,   7'd3,   3'b001, 1'b1, 15'd1, 15'd0, 15'd0, 15'd0};
        vecs[1] = '{8'd5,   7'd3,   3'b001, 1'b0, 15'd1, 15'd0, 15'd0, 15'd0};
        vecs[2] = '{8'd5,   7'd3,   3'b010, 1'b1, 15'd0, 15'd1, 15'd0, 15'd0};
        vecs[3] = '{8'd10,  7'd20,  3'b100, 1'b1, 15'd0, 15'd1, 15'd1, 15'd0};
        vecs[4] = '{8'd10,  7'd20,  3'b011, 1'b1, 15'd0, 15'd1, 15'd0, 15'd0};
        vecs[5] = '{8'd0,   7'd127, 3'b110, 1'b1, 15'd0, 15'd1, 15'd0, 15'd1};
        vecs[6] = '{8'd255, 7'd0,   3'b000, 1'b0, 15'd0, 15'd1, 15'd0, 15'd1};
        vecs[7] = '{8'd0,   7'd127, 3'b000, 1'b1, 15'd0, 15'd1, 15'd0, 15'd0};
        vecs[8] = '{8'd1,   7'd1,   3'b111, 1'b1, 15'd0, 15'd1, 15'd0, 15'd0};
        vecs[9] = '{8'd1,   7'd1,   3'b001, 1'b1, 15'd1, 15'd1, 15'd0, 15'd0};

        bx = '{8'd20, 8'd21, 8'd22, 8'd20, 8'd23, 8'd24};
        bc = '{3'b001, 3'b001, 3'b010, 3'b100, 3'b110, 3'b001};
        exp_log[0] = {8'd20, 7'd20, 3'b001};
        exp_log[1] = {8'd21, 7'd20, 3'b001};
        exp_log[2] = {8'd22, 7'd20, 3'b010};
        exp_log[3] = {8'd20, 7'd20, 3'b100};
        exp_log[4] = {8'd23, 7'd20, 3'b110};

        reset = 1'b1; plot = 1'b0; clear = 1'b0; x = '0; y = '0; colour = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("reset_ready",   32'(ready), 32'd1);
        check("reset_busy",    32'(busy), 32'd0);
        check("reset_wren",    32'(ram_wren), 32'd0);
        check("reset_addr",    32'(ram_address), 32'd0);
        check("reset_data",    32'(ram_data), 32'd0);
        check("reset_dropped", 32'(dropped), 32'd0);
        check("reset_counts",  32'(p1_count | p2_count | p3_count | p4_count), 32'd0);

        // Single plots into an idle sink: push edge, READ, UPDATE.
        for (int i = 0; i < 10; i++) begin
            x = vecs[i].vx; y = vecs[i].vy; colour = vecs[i].vc; plot = 1'b1;
            tick();
            plot = 1'b0;
            tick();
            check("read_addr", 32'(ram_address), 32'({vecs[i].vx, vecs[i].vy}));
            check("read_wren", 32'(ram_wren), 32'd0);
            tick();
            check("upd_wren", 32'(ram_wren), 32'(vecs[i].wr));
            if (vecs[i].wr) begin
                check("upd_addr", 32'(ram_address), 32'({vecs[i].vx, vecs[i].vy}));
                check("upd_data", 32'(ram_data), 32'(vecs[i].vc));
            end
            tick();
            check("vec_mem", 32'(mem[{vecs[i].vx, vecs[i].vy}]), 32'(vecs[i].vc));
            check("vec_p1", 32'(p1_count), 32'(vecs[i].e1));
            check("vec_p2", 32'(p2_count), 32'(vecs[i].e2));
            check("vec_p3", 32'(p3_count), 32'(vecs[i].e3));
            check("vec_p4", 32'(p4_count), 32'(vecs[i].e4));
            check("vec_busy", 32'(busy), 32'd0);
        end
        check("first_addr_0283", 32'(vecs[0].vx) * 128 + 32'(vecs[0].vy), 32'h0283);
        check("pre_burst_dropped", 32'(dropped), 32'd0);

        // Six back-to-back plots into a four-deep FIFO: the sixth is lost.
        log_en = 1'b1;
        y = 7'd20;
        for (int i = 0; i < 6; i++) begin
            x = bx[i]; colour = bc[i]; plot = 1'b1;
            tick();
            if (i == 4) check("burst_ready_low", 32'(ready), 32'd0);
        end
        plot = 1'b0;
        cyc = 0;
        while (busy && cyc < 100) begin
            tick();
            cyc++;
        end
        log_en = 1'b0;
        check("burst_drain", 32'(busy), 32'd0);
        check("burst_dropped", 32'(dropped), 32'd1);
        check("burst_nwrites", 32'(wlog.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            act = (i < wlog.size()) ? wlog[i] : 18'h3FFFF;
            check("burst_write_order", 32'(act), 32'(exp_log[i]));
        end
        check("burst_lost_pixel", 32'(mem[{8'd24, 7'd20}]), 32'd0);
        check("burst_p1", 32'(p1_count), 32'd2);
        check("burst_p2", 32'(p2_count), 32'd2);
        check("burst_p3", 32'(p3_count), 32'd1);
        check("burst_p4", 32'(p4_count), 32'd1);

        // Clear requested during an UPDATE: the write lands, then the sweep runs.
        x = 8'd30; y = 7'd30; colour = 3'b010; plot = 1'b1;
        tick();
        plot = 1'b0;
        tick();
        tick();
        check("clr_upd_wren", 32'(ram_wren), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_upd_mem", 32'(mem[{8'd30, 7'd30}]), 32'd2);
        check("clr_pend_ready", 32'(ready), 32'd0);
        check("clr_pre_p2", 32'(p2_count), 32'd3);
        clr_writes = 0;
        clr_mon = 1'b1;
        cyc = 0;
        while (!ready && cyc < 40000) begin
            tick();
            cyc++;
        end
        clr_mon = 1'b0;
        check("clr_ready", 32'(ready), 32'd1);
        check("clr_duration", 32'(cyc), 32'd32769);
        check("clr_writes", 32'(clr_writes), 32'd32768);
        check("clr_counts", 32'(p1_count | p2_count | p3_count | p4_count), 32'd0);
        check("clr_dropped", 32'(dropped), 32'd0);
        check("clr_busy", 32'(busy), 32'd0);
        bad = 0;
        for (int a = 0; a < 32768; a++) begin
            if (mem[a] !== 3'b000) bad++;
        end
        check("clr_ram_zero", 32'(bad), 32'd0);

        // Reset during UPDATE with a second command queued behind it.
        x = 8'd2; y = 7'd2; colour = 3'b001; plot = 1'b1;
        tick();
        plot = 1'b0;
        repeat (3) tick();
        check("rst_pre_p1", 32'(p1_count), 32'd1);
        x = 8'd3; y = 7'd3; colour = 3'b010; plot = 1'b1;
        tick();
        x = 8'd4; y = 7'd4; colour = 3'b100;
        tick();
        plot = 1'b0;
        tick();
        check("rst_upd_wren", 32'(ram_wren), 32'd1);
        reset = 1'b1;
        tick();
        check("rst_wren", 32'(ram_wren), 32'd0);
        check("rst_counts", 32'(p1_count | p2_count | p3_count | p4_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr", 32'(ram_address), 32'd0);
        reset = 1'b0;
        repeat (6) tick();
        check("rst_no_write_a", 32'(mem[{8'd3, 7'd3}]), 32'd0);
        check("rst_fifo_empty", 32'(mem[{8'd4, 7'd4}]), 32'd0);
        check("rst_idle_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
